// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: handshake bundle for the UART receive FIFO.
//   Write side : i_wr_stb, i_wr_data (receiver done strobe + byte)
//   Read side  : o_valid, o_data, i_ready (first-word-fall-through)
//   Status     : o_count, o_full, o_empty, o_overflow, i_ovf_clr, o_timeout
// Modports: slave = FIFO, master = producer/consumer driving it.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_W     = 4
);
  logic                  i_wr_stb;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_ready;
  logic [ADDR_W:0]       o_count;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_overflow;
  logic                  i_ovf_clr;
  logic                  o_timeout;

  modport slave (
    input  i_wr_stb, i_wr_data, i_ready, i_ovf_clr,
    output o_valid, o_data, o_count, o_full, o_empty, o_overflow, o_timeout
  );

  modport master (
    output i_wr_stb, i_wr_data, i_ready, i_ovf_clr,
    input  o_valid, o_data, o_count, o_full, o_empty, o_overflow, o_timeout
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer behind the UART receiver.
// Captures each strobed byte, presents the head through a FWFT valid/ready
// port, and raises a sticky overflow flag when a byte arrives while full
// with no pop in the same cycle.
// Ports:
//   sysclk : system clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : uart_rx_fifo_if.slave (write strobe/data, valid/data/ready,
//            count/full/empty, overflow + clear, timeout)
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to enable the idle-timeout
// pulse (parameter IDLE_CLKS); otherwise o_timeout is tied low.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4
`ifdef UART_RX_FIFO_TIMEOUT_EN
  , parameter int unsigned IDLE_CLKS = 10416
`endif
) (
  input  logic           sysclk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  not_empty, is_full, pop, wr_acc, wr_drop;

  always_comb begin
    not_empty = (count_q != '0);
    is_full   = (count_q == FULL_CNT);
    pop       = not_empty & bus.i_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    wr_acc    = bus.i_wr_stb & (~is_full | pop);
    wr_drop   = bus.i_wr_stb & is_full & ~pop;

    wr_ptr_d = wr_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    count_d = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear.
    ovf_d = wr_drop | (ovf_q & ~bus.i_ovf_clr);
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge sysclk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus.i_wr_data;
  end

  always_comb begin
    bus.o_valid    = not_empty;
    bus.o_data     = not_empty ? mem_q[rd_ptr_q] : '0;
    bus.o_count    = count_q;
    bus.o_full     = is_full;
    bus.o_empty    = ~not_empty;
    bus.o_overflow = ovf_q;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic [13:0] IDLE_MAX = 14'(IDLE_CLKS);

  logic [13:0] idle_q, idle_d;
  logic        tmo_q, tmo_d;

  always_comb begin
    idle_d = idle_q;
    if (wr_acc || !not_empty) idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + 14'd1;
    // Fires on the single step IDLE_MAX-1 -> IDLE_MAX; saturation blocks repeats.
    tmo_d = not_empty && !wr_acc && (idle_q == IDLE_MAX - 14'd1);
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
    end
  end

  assign bus.o_timeout = tmo_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_WIDTH(8), .ADDR_W(4)) bus ();

  uart_rx_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(16),
    .ADDR_W(4)
`ifdef UART_RX_FIFO_TIMEOUT_EN
    , .IDLE_CLKS(20)
`endif
  ) dut (
    .sysclk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    bus.i_wr_stb  = 1'b1;
    bus.i_wr_data = b;
    tick();
    bus.i_wr_stb  = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    int         sent, got, cyc, first_k, highs;
    logic       stb;

    rst = 1'b1;
    bus.i_wr_stb = 1'b1; bus.i_wr_data = 8'h99;
    bus.i_ready = 1'b0; bus.i_ovf_clr = 1'b0;
    tick(); tick();
    bus.i_wr_stb = 1'b0;
    rst = 1'b0;
    tick();

    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_data", 32'(bus.o_data), 0);
    chk("rst_empty", 32'(bus.o_empty), 1);
    chk("rst_full", 32'(bus.o_full), 0);
    chk("rst_ovf", 32'(bus.o_overflow), 0);
    chk("rst_tmo", 32'(bus.o_timeout), 0);

    wr(8'h41); wr(8'h42); wr(8'h43);
    chk("w3_count", 32'(bus.o_count), 3);
    chk("w3_data", 32'(bus.o_data), 32'h41);
    chk("w3_valid", 32'(bus.o_valid), 1);
    chk("w3_empty", 32'(bus.o_empty), 0);

    bus.i_ready = 1'b1;
    chk("pop0", 32'(bus.o_data), 32'h41); tick();
    chk("pop1", 32'(bus.o_data), 32'h42); tick();
    chk("pop2", 32'(bus.o_data), 32'h43); tick();
    bus.i_ready = 1'b0;
    chk("drain_empty", 32'(bus.o_empty), 1);
    chk("drain_data", 32'(bus.o_data), 0);
    chk("drain_valid", 32'(bus.o_valid), 0);
    chk("drain_count", 32'(bus.o_count), 0);

    // Empty with write and ready together: no pop happens.
    bus.i_ready = 1'b1;
    wr(8'h77);
    chk("ew_count", 32'(bus.o_count), 1);
    chk("ew_data", 32'(bus.o_data), 32'h77);
    tick();
    bus.i_ready = 1'b0;
    chk("ew_drain", 32'(bus.o_count), 0);

    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_full", 32'(bus.o_full), 1);
    chk("fill_count", 32'(bus.o_count), 16);
    chk("fill_ovf0", 32'(bus.o_overflow), 0);
    wr(8'hAA);
    chk("ovf_set", 32'(bus.o_overflow), 1);
    chk("ovf_count", 32'(bus.o_count), 16);
    chk("ovf_full", 32'(bus.o_full), 1);
    chk("ovf_head", 32'(bus.o_data), 0);
    bus.i_ovf_clr = 1'b1; tick(); bus.i_ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.o_overflow), 0);

    bus.i_ovf_clr = 1'b1; wr(8'hAB); bus.i_ovf_clr = 1'b0;
    chk("ovf_setwins", 32'(bus.o_overflow), 1);
    bus.i_ovf_clr = 1'b1; tick(); bus.i_ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(bus.o_overflow), 0);

    // Full: write and pop in the same cycle.
    bus.i_ready = 1'b1;
    wr(8'h55);
    bus.i_ready = 1'b0;
    chk("fwp_count", 32'(bus.o_count), 16);
    chk("fwp_ovf", 32'(bus.o_overflow), 0);
    chk("fwp_head", 32'(bus.o_data), 1);
    bus.i_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("fwp_seq", 32'(bus.o_data), (i == 16) ? 32'h55 : 32'(i));
      tick();
    end
    bus.i_ready = 1'b0;
    chk("fwp_empty", 32'(bus.o_empty), 1);

    // Stream 40 bytes with random ready gaps across pointer wrap.
    sent = 0; got = 0; cyc = 0;
    while (got < 40 && cyc < 600) begin
      stb = (sent < 40) && (q.size() < 16) && ($urandom_range(0, 3) != 0);
      bus.i_wr_stb  = stb;
      bus.i_wr_data = 8'(sent);
      bus.i_ready   = 1'($urandom_range(0, 1));
      chk("wrap_count", 32'(bus.o_count), 32'(q.size()));
      if (bus.i_ready && q.size() > 0)
        chk("wrap_data", 32'(bus.o_data), 32'(q[0]));
      tick();
      if (bus.i_ready && q.size() > 0) begin
        void'(q.pop_front());
        got++;
      end
      if (stb) begin
        q.push_back(8'(sent));
        sent++;
      end
      cyc++;
    end
    bus.i_wr_stb = 1'b0; bus.i_ready = 1'b0;
    chk("wrap_got", 32'(got), 40);
    chk("wrap_ovf", 32'(bus.o_overflow), 0);
    chk("wrap_empty", 32'(bus.o_empty), 1);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    wr(8'h10);
    first_k = -1; highs = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.o_timeout) begin
        highs++;
        if (first_k < 0) first_k = k;
      end
    end
    chk("tmo_at", 32'(first_k), 20);
    chk("tmo_once", 32'(highs), 1);

    wr(8'h11);
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    highs = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.o_timeout) highs++;
    end
    chk("tmo_rst", 32'(highs), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
